// File: rtl/gb80_bus_pkg.sv
// gb80_bus_pkg: shared definitions for the GB80 memory bus arbiter.
//   - requester indices (CPU, OAM DMA, PPU) and requester count
//   - arbiter state encoding
package gb80_bus_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DMA = 1;
  localparam int unsigned REQ_PPU = 2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_bus_priority_sel.sv
// mem_bus_priority_sel: combinational winner selection for the GB80 bus.
//   req_i    : requests already masked by the arbiter (bit0 CPU, bit1 DMA, bit2 PPU)
//   lock_i   : DMA burst lock in effect; only DMA may win
//   starve_i : CPU starvation limit reached; CPU beats DMA and PPU
//   win_o    : one-hot winner, all zero when nobody may win
module mem_bus_priority_sel
  import gb80_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               lock_i,
  input  logic               starve_i,
  output logic [NUM_REQ-1:0] win_o
);

  always_comb begin
    win_o = '0;
    if (lock_i) begin
      // A held lock idles the bus rather than letting anyone else in.
      win_o[REQ_DMA] = req_i[REQ_DMA];
    end else if (starve_i && req_i[REQ_CPU]) begin
      win_o[REQ_CPU] = 1'b1;
    end else if (req_i[REQ_DMA]) begin
      win_o[REQ_DMA] = 1'b1;
    end else if (req_i[REQ_PPU]) begin
      win_o[REQ_PPU] = 1'b1;
    end else if (req_i[REQ_CPU]) begin
      win_o[REQ_CPU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the GB80 memory bus between CPU (req 0),
// OAM DMA (req 1) and PPU video fetch (req 2).
//   i_clk, i_reset_n     : clock, synchronous active-low reset
//   i_req/i_wr           : per-requester request and write flag
//   i_addr/i_wdata       : per-requester address / write data, slice k per requester
//   i_dma_lock           : DMA keeps the bus across its burst
//   o_gnt/o_ack          : one-hot owner during access / one-cycle completion pulse
//   o_rdata              : read data, updated on read acks and held
//   o_busy               : access in progress
//   o_mem_*              : registered memory-side address, data and strobes
//   i_mem_rdata          : memory read data, sampled on the last access cycle
module mem_bus_arbiter
  import gb80_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  input  logic                          i_dma_lock,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_busy,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  output logic                          o_mem_rd,
  output logic                          o_mem_wr,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata
);

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e                state_q, state_d;
  logic [3:0]                wait_cnt_q, wait_cnt_d;
  logic [3:0]                starve_cnt_q, starve_cnt_d;
  logic                      lock_q, lock_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      mem_rd_q, mem_rd_d;
  logic                      mem_wr_q, mem_wr_d;

  logic [NUM_REQ-1:0]        req_masked;
  logic                      lock_eff;
  logic                      starve;
  logic [NUM_REQ-1:0]        win;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;
  logic                      sel_wr;

  // A requester whose ack is on the wire still has its stale req up.
  assign req_masked = i_req & ~ack_q;
  // Dropping i_dma_lock releases the bus in the same arbitration.
  assign lock_eff   = lock_q & i_dma_lock;
  assign starve     = (starve_cnt_q == STARVE_MAX);

  mem_bus_priority_sel u_sel (
    .req_i    (req_masked),
    .lock_i   (lock_eff),
    .starve_i (starve),
    .win_o    (win)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        sel_addr  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_wr    = i_wr[k];
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      lock_q       <= 1'b0;
      gnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      lock_q       <= lock_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|win) state_d = S_ACCESS;
      S_ACCESS: if (wait_cnt_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. The memory address and data registers
  // double as the access latches, and o_gnt doubles as the owner latch.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    lock_d       = lock_q;
    gnt_d        = gnt_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (win[REQ_DMA] && i_dma_lock) begin
          lock_d = 1'b1;
        end else if (!i_dma_lock) begin
          lock_d = 1'b0;
        end
        if (!req_masked[REQ_CPU] || win[REQ_CPU]) begin
          starve_cnt_d = '0;
        end else if (!lock_eff && (starve_cnt_q != STARVE_MAX)) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
        if (|win) begin
          gnt_d       = win;
          busy_d      = 1'b1;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_rd_d    = !sel_wr;
          mem_wr_d    = sel_wr;
          wait_cnt_d  = WAIT_INIT;
        end
      end
      S_ACCESS: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          if (mem_rd_q) rdata_d = i_mem_rdata;
          ack_d    = gnt_q;
          gnt_d    = '0;
          busy_d   = 1'b0;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_gnt       = gnt_q;
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = busy_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_rd    = mem_rd_q;
  assign o_mem_wr    = mem_wr_q;

endmodule
